quad_step_decoder: RTL

//   Quadrature (A/B) front end for the up/down counter. Synchronises and glitch-filters two
//   raw encoder lines and decodes the Gray sequence into a one-cycle step pulse plus direction.
//   o_step drives the counter's i_en and o_up_down drives its i_up_down. Direction is settled
//   one cycle before each step, because the counter registers direction internally.

---
 rtl/qdec_pkg.sv | 46 ++++
 rtl/glitch_filter.sv | 52 +++++
 rtl/quad_step_decoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature step decoder.
//
// Contents:
//   QS_00 .. QS_10  {A,B} levels of the quadrature Gray cycle, listed in
//                   forward order 00 -> 01 -> 11 -> 10 -> 00.
//   qdec_t          decode result: legal / move / dir.
//   qdec_decode()   classifies one filtered transition prev -> cur.
package qdec_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  // legal : 0 only when both channels changed at once
  // move  : 1 when exactly one channel changed (a real quadrature edge)
  // dir   : 1 = forward Gray order, 0 = reverse; only meaningful with move
  typedef struct packed {
    logic legal;
    logic move;
    logic dir;
  } qdec_t;

  function automatic qdec_t qdec_decode(input logic [1:0] prev, input logic [1:0] cur);
    qdec_t r;
    r.legal = 1'b1;
    r.move  = 1'b0;
    r.dir   = 1'b1;
    if (prev != cur) begin
      if ((prev ^ cur) == 2'b11) begin
        r.legal = 1'b0;
      end else begin
        r.move = 1'b1;
        // Forward if cur is the successor of prev in the Gray cycle.
        case (prev)
          QS_00:   r.dir = (cur == QS_01);
          QS_01:   r.dir = (cur == QS_11);
          QS_11:   r.dir = (cur == QS_10);
          default: r.dir = (cur == QS_00);
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// Single-channel front end: 2-flop synchroniser followed by a level filter
// that accepts a new level only after FILT_LEN consecutive samples of it.
//
// Ports:
//   clk   in  rising-edge clock
//   sclr  in  synchronous active-high reset, clears sync flops, counter, level
//   init  in  1 = initialisation window: load the synchronised level directly
//   raw   in  asynchronous encoder line
//   filt  out filtered level
module glitch_filter #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic sclr,
  input  logic init,
  input  logic raw,
  output logic filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (sclr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (init) begin
        // Adopt whatever level the line sits at, so no edge is reported
        // when the block comes out of reset.
        filt <= sync2;
        cnt  <= '0;
      end else if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end for the up/down counter.
//
// Both raw lines are synchronised and glitch-filtered, then the filtered
// {A,B} pair is decoded as a Gray sequence into a one-cycle step pulse plus
// a direction level. Direction is registered one cycle ahead of the step so
// the downstream counter sees it settled when it samples its enable.
//
// Ports:
//   i_clk        in  clock, sole domain
//   i_sclr       in  synchronous active-high reset
//   i_en         in  step enable; 0 suppresses o_step/o_err, filter keeps tracking
//   i_a, i_b     in  raw encoder channels, asynchronous
//   o_step       out one-cycle pulse per accepted quadrature edge
//   o_up_down    out 1 = up, 0 = down; held between steps
//   o_err        out one-cycle pulse on a both-channels-changed transition
//   o_err_sticky out latched o_err, cleared only by reset
//   o_ready      out 0 during the post-reset initialisation window, then 1
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int FILT_LEN   = 4,
  parameter int CNT_W      = 3,
  parameter bit INVERT_DIR = 1'b0
) (
  input  logic i_clk,
  input  logic i_sclr,
  input  logic i_en,
  input  logic i_a,
  input  logic i_b,
  output logic o_step,
  output logic o_up_down,
  output logic o_err,
  output logic o_err_sticky,
  output logic o_ready
);

  // Window covers the two synchroniser stages plus the filter depth.
  localparam int INIT_LEN = FILT_LEN + 2;
  localparam int INIT_W   = $clog2(INIT_LEN + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);

  logic              init;
  logic [INIT_W-1:0] init_cnt;
  logic [1:0]        filt;
  logic [1:0]        prev;
  qdec_t             dec;
  logic              dir_next;
  logic              move_ok;
  logic              bad_jump;
  logic              step_p1;

  assign init = ~o_ready;

  glitch_filter #(
    .FILT_LEN(FILT_LEN),
    .CNT_W   (CNT_W)
  ) u_filt_a (
    .clk (i_clk),
    .sclr(i_sclr),
    .init(init),
    .raw (i_a),
    .filt(filt[1])
  );

  glitch_filter #(
    .FILT_LEN(FILT_LEN),
    .CNT_W   (CNT_W)
  ) u_filt_b (
    .clk (i_clk),
    .sclr(i_sclr),
    .init(init),
    .raw (i_b),
    .filt(filt[0])
  );

  // Initialisation window counter; o_ready rises on the last window edge.
  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      init_cnt <= '0;
      o_ready  <= 1'b0;
    end else if (!o_ready) begin
      init_cnt <= init_cnt + INIT_W'(1);
      if (init_cnt == INIT_LAST) o_ready <= 1'b1;
    end
  end

  // Decode of the filtered pair against its value one edge earlier.
  assign dec      = qdec_decode(prev, filt);
  assign dir_next = dec.dir ^ INVERT_DIR;
  assign move_ok  = ~init & dec.legal & dec.move;
  assign bad_jump = ~init & ~dec.legal;

  // ---- stage p1: direction to output, enable sampled, error flagged ----
  // ---- stage p2: step pulse leaves one cycle after its direction ----
  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      prev         <= QS_00;
      step_p1      <= 1'b0;
      o_step       <= 1'b0;
      o_up_down    <= 1'b1;
      o_err        <= 1'b0;
      o_err_sticky <= 1'b0;
    end else begin
      prev    <= filt;
      step_p1 <= move_ok & i_en;
      // Direction follows every legal edge, even with i_en low, so the
      // counter's direction input never lags the encoder.
      if (move_ok) o_up_down <= dir_next;
      o_err   <= bad_jump & i_en;
      if (bad_jump & i_en) o_err_sticky <= 1'b1;
      o_step  <= step_p1;
    end
  end

endmodule
